// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: forwarding selects,
// controller FSM states and the destination-match helper used by forwarding.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        CTRL_RUN      = 1'b0,
        CTRL_MEM_WAIT = 1'b1
    } ctrl_state_t;

    // x0 is hard-wired to zero, so a write to it never produces a usable result
    function automatic logic rd_match(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand bypass select for one EX source register; the younger (MEM) result
// takes precedence over the older (WB) one.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs_addr_i,
    input  logic       mem_write_rd_i,
    input  logic [4:0] mem_rd_addr_i,
    input  logic       wb_write_rd_i,
    input  logic [4:0] wb_rd_addr_i,
    output fwd_sel_t   fwd_sel_o
);

    // Pick the newest in-flight producer of this operand
    always_comb begin
        if (rd_match(mem_write_rd_i, mem_rd_addr_i, ex_rs_addr_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (rd_match(wb_write_rd_i, wb_rd_addr_i, ex_rs_addr_i)) begin
            fwd_sel_o = FWD_WB;
        end else begin
            fwd_sel_o = FWD_NONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: data-memory wait/timeout FSM, load-use interlock, redirect
// flushes and EX operand forwarding for a five-stage in-order core.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic [4:0] ex_rs1_addr_i,
    input  logic [4:0] ex_rs2_addr_i,
    input  logic       ex_write_rd_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_wb_use_mem_i,
    input  logic       ex_load_pc_i,
    input  logic       mem_write_rd_i,
    input  logic [4:0] mem_rd_addr_i,
    input  logic       mem_oper_valid_i,
    input  logic       dmem_ack_i,
    input  logic       wb_write_rd_i,
    input  logic [4:0] wb_rd_addr_i,
    output logic       pc_stall_o,
    output logic       ifid_stall_o,
    output logic       ifid_flush_o,
    output logic       idex_stall_o,
    output logic       idex_flush_o,
    output logic       exmem_stall_o,
    output logic       exmem_flush_o,
    output logic [1:0] fwd_rs1_sel_o,
    output logic [1:0] fwd_rs2_sel_o,
    output logic       bus_err_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_hold_s;
    logic          timeout_s;
    logic          hazard_en_s;
    logic          load_use_s;
    logic          redirect_s;
    fwd_sel_t      fwd_rs1_s;
    fwd_sel_t      fwd_rs2_s;

    // Memory wait FSM next state, wait counter and hold/timeout decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_hold_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            CTRL_RUN: begin
                if (mem_oper_valid_i && !dmem_ack_i) begin
                    mem_hold_s = 1'b1;
                    state_d    = CTRL_MEM_WAIT;
                    cnt_d      = CW'(1);
                end else begin
                    cnt_d      = '0;
                end
            end
            CTRL_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = CTRL_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(MEM_TIMEOUT)) begin
                    timeout_s = 1'b1;
                    state_d   = CTRL_RUN;
                    cnt_d     = '0;
                end else begin
                    mem_hold_s = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state and wait counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= CTRL_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect outranks load-use; both are masked while memory holds the pipe
    always_comb begin
        hazard_en_s = !mem_hold_s && !timeout_s;
        redirect_s  = hazard_en_s && ex_load_pc_i;
        load_use_s  = hazard_en_s && !ex_load_pc_i && ex_wb_use_mem_i &&
                      (rd_match(ex_write_rd_i, ex_rd_addr_i, id_rs1_addr_i) ||
                       rd_match(ex_write_rd_i, ex_rd_addr_i, id_rs2_addr_i));
    end

    // On timeout the upstream stages stay frozen while the failed MEM op is bubbled out
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        exmem_flush_o = 1'b0;
        bus_err_o     = 1'b0;
        if (rstn_i) begin
            pc_stall_o    = mem_hold_s || timeout_s || load_use_s;
            ifid_stall_o  = mem_hold_s || timeout_s || load_use_s;
            ifid_flush_o  = redirect_s;
            idex_stall_o  = mem_hold_s || timeout_s;
            idex_flush_o  = redirect_s || load_use_s;
            exmem_stall_o = mem_hold_s;
            exmem_flush_o = timeout_s;
            bus_err_o     = timeout_s;
        end else begin
            bus_err_o     = 1'b0;
        end
    end

    forward_unit u_fwd_rs1 (
        .ex_rs_addr_i   (ex_rs1_addr_i),
        .mem_write_rd_i (mem_write_rd_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .wb_write_rd_i  (wb_write_rd_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .fwd_sel_o      (fwd_rs1_s)
    );

    forward_unit u_fwd_rs2 (
        .ex_rs_addr_i   (ex_rs2_addr_i),
        .mem_write_rd_i (mem_write_rd_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .wb_write_rd_i  (wb_write_rd_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .fwd_sel_o      (fwd_rs2_s)
    );

    assign fwd_rs1_sel_o = fwd_rs1_s;
    assign fwd_rs2_sel_o = fwd_rs2_s;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized bench for pipeline_ctrl, checked against a
// cycle-level behavioural model of the stall/flush/forward rules.
module tb_pipeline_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i;
    logic       ex_write_rd_i, ex_wb_use_mem_i, ex_load_pc_i;
    logic [4:0] ex_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i;
    logic       mem_write_rd_i, mem_oper_valid_i, dmem_ack_i, wb_write_rd_i;
    logic       pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
    logic       exmem_stall_o, exmem_flush_o, bus_err_o;
    logic [1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;

    int tests = 0;
    int fails = 0;
    int pend  = 0;   // cycles the current MEM access has been outstanding

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_write_rd_i(ex_write_rd_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_wb_use_mem_i(ex_wb_use_mem_i), .ex_load_pc_i(ex_load_pc_i),
        .mem_write_rd_i(mem_write_rd_i), .mem_rd_addr_i(mem_rd_addr_i),
        .mem_oper_valid_i(mem_oper_valid_i), .dmem_ack_i(dmem_ack_i),
        .wb_write_rd_i(wb_write_rd_i), .wb_rd_addr_i(wb_rd_addr_i),
        .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
        .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o),
        .exmem_stall_o(exmem_stall_o), .exmem_flush_o(exmem_flush_o),
        .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
        .bus_err_o(bus_err_o)
    );

    function automatic logic [7:0] ctrl_obs();
        return {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                idex_flush_o, exmem_stall_o, exmem_flush_o, bus_err_o};
    endfunction

    function automatic logic [7:0] ctrl_model(input int p);
        bit hold, tmo, free, redir, lu;
        if (!rstn_i) return 8'h00;
        hold  = (p == 0) ? (mem_oper_valid_i && !dmem_ack_i) : (!dmem_ack_i && p < T);
        tmo   = (p != 0) && !dmem_ack_i && (p >= T);
        free  = !hold && !tmo;
        redir = free && ex_load_pc_i;
        lu    = free && !ex_load_pc_i && ex_wb_use_mem_i && ex_write_rd_i &&
                ex_rd_addr_i != 5'd0 &&
                (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
        return {hold | tmo | lu, hold | tmo | lu, redir, hold | tmo,
                redir | lu, hold, tmo, tmo};
    endfunction

    function automatic int next_pend(input int p);
        if (!rstn_i) return 0;
        if (p == 0) return (mem_oper_valid_i && !dmem_ack_i) ? 1 : 0;
        if (dmem_ack_i || p >= T) return 0;
        return p + 1;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (mem_write_rd_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == rs) return 2'd1;
        if (wb_write_rd_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check({tag, "_ctrl"}, {24'd0, ctrl_obs()}, {24'd0, ctrl_model(pend)});
        check({tag, "_fwd1"}, {30'd0, fwd_rs1_sel_o}, {30'd0, fwd_model(ex_rs1_addr_i)});
        check({tag, "_fwd2"}, {30'd0, fwd_rs2_sel_o}, {30'd0, fwd_model(ex_rs2_addr_i)});
    endtask

    task automatic adv();
        @(posedge clk);
        pend = next_pend(pend);
        #1;
    endtask

    task automatic idle();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        ex_rs1_addr_i = 5'd0; ex_rs2_addr_i = 5'd0;
        ex_write_rd_i = 1'b0; ex_rd_addr_i = 5'd0;
        ex_wb_use_mem_i = 1'b0; ex_load_pc_i = 1'b0;
        mem_write_rd_i = 1'b0; mem_rd_addr_i = 5'd0;
        mem_oper_valid_i = 1'b0; dmem_ack_i = 1'b0;
        wb_write_rd_i = 1'b0; wb_rd_addr_i = 5'd0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_wb_use_mem_i = 1'b1; ex_write_rd_i = 1'b1; ex_rd_addr_i = rd;
        id_rs1_addr_i = 5'd3; id_rs2_addr_i = 5'd5;
    endtask

    initial begin
        idle();
        rstn_i = 1'b0;
        step("reset");
        check("reset_all_zero", {24'd0, ctrl_obs()}, 32'd0);
        adv();
        rstn_i = 1'b1;
        adv();

        // load-use on rs2, then bubble
        set_load_use(5'd5);
        step("lu");
        check("lu_stall_flush", {29'd0, pc_stall_o, ifid_stall_o, idex_flush_o}, 32'd7);
        adv();
        idle();
        step("lu_after");
        check("lu_after_zero", {24'd0, ctrl_obs()}, 32'd0);
        adv();
        set_load_use(5'd0);
        step("lu_x0");
        check("lu_x0_no_stall", {31'd0, pc_stall_o}, 32'd0);
        adv();

        // redirect overrides load-use
        set_load_use(5'd5);
        ex_load_pc_i = 1'b1;
        step("redir");
        check("redir_flush", {30'd0, ifid_flush_o, idex_flush_o}, 32'd3);
        check("redir_no_stall", {30'd0, pc_stall_o, ifid_stall_o}, 32'd0);
        adv();
        idle();

        // memory access acknowledged after three stalled cycles
        mem_oper_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step("mw");
            check("mw_stalls", {28'd0, pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o}, 32'hf);
            adv();
        end
        dmem_ack_i = 1'b1;
        step("mw_ack");
        check("mw_ack_zero", {24'd0, ctrl_obs()}, 32'd0);
        adv();
        idle();
        step("mw_run");
        check("mw_back_run", {24'd0, ctrl_obs()}, 32'd0);
        adv();

        // timeout: miss cycle plus four wait cycles, error on the fourth
        mem_oper_valid_i = 1'b1;
        step("to_miss");
        adv();
        for (int c = 1; c <= T; c++) begin
            step("to_wait");
            check("to_buserr", {31'd0, bus_err_o}, (c == T) ? 32'd1 : 32'd0);
            check("to_exmem_flush", {31'd0, exmem_flush_o}, (c == T) ? 32'd1 : 32'd0);
            adv();
        end
        mem_oper_valid_i = 1'b0;
        step("to_run");
        check("to_run_zero", {24'd0, ctrl_obs()}, 32'd0);
        adv();

        // forwarding priority and x0
        ex_rs1_addr_i = 5'd7;
        mem_write_rd_i = 1'b1; mem_rd_addr_i = 5'd7;
        wb_write_rd_i = 1'b1; wb_rd_addr_i = 5'd7;
        step("fwd_mem");
        check("fwd_mem_sel", {30'd0, fwd_rs1_sel_o}, 32'd1);
        mem_write_rd_i = 1'b0;
        step("fwd_wb");
        check("fwd_wb_sel", {30'd0, fwd_rs1_sel_o}, 32'd2);
        ex_rs1_addr_i = 5'd0; mem_write_rd_i = 1'b1;
        mem_rd_addr_i = 5'd0; wb_rd_addr_i = 5'd0;
        step("fwd_x0");
        check("fwd_x0_sel", {30'd0, fwd_rs1_sel_o}, 32'd0);
        adv();
        idle();

        // reset in the middle of a wait, held past the timeout length
        mem_oper_valid_i = 1'b1;
        step("rst_miss");
        adv();
        step("rst_wait");
        adv();
        rstn_i = 1'b0;
        pend = 0;
        #1;
        check("rst_mid_zero", {24'd0, ctrl_obs()}, 32'd0);
        for (int c = 0; c < T + 2; c++) begin
            step("rst_hold");
            check("rst_no_buserr", {31'd0, bus_err_o}, 32'd0);
            adv();
        end
        mem_oper_valid_i = 1'b0;
        rstn_i = 1'b1;
        step("rst_release");
        adv();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            id_rs1_addr_i    = 5'($urandom_range(0, 3));
            id_rs2_addr_i    = 5'($urandom_range(0, 3));
            ex_rs1_addr_i    = 5'($urandom_range(0, 3));
            ex_rs2_addr_i    = 5'($urandom_range(0, 3));
            ex_rd_addr_i     = 5'($urandom_range(0, 3));
            mem_rd_addr_i    = 5'($urandom_range(0, 3));
            wb_rd_addr_i     = 5'($urandom_range(0, 3));
            ex_write_rd_i    = 1'($urandom_range(0, 1));
            ex_wb_use_mem_i  = 1'($urandom_range(0, 1));
            ex_load_pc_i     = ($urandom_range(0, 4) == 0);
            mem_write_rd_i   = 1'($urandom_range(0, 1));
            wb_write_rd_i    = 1'($urandom_range(0, 1));
            mem_oper_valid_i = ($urandom_range(0, 2) == 0);
            dmem_ack_i       = ($urandom_range(0, 4) == 0);
            step("rnd");
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max cycles spent waiting for a data-memory acknowledge before abort.
REQ-002 clk_i  input  1  core clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 id_rs1_addr_i  input  5  rs1 index of the instruction in ID.
REQ-005 id_rs2_addr_i  input  5  rs2 index of the instruction in ID.
REQ-006 ex_rs1_addr_i  input  5  rs1 index of the instruction in EX.
REQ-007 ex_rs2_addr_i  input  5  rs2 index of the instruction in EX.
REQ-008 ex_write_rd_i  input  1  EX instruction writes rd.
REQ-009 ex_rd_addr_i  input  5  EX destination index.
REQ-010 ex_wb_use_mem_i  input  1  EX instruction is a load.
REQ-011 ex_load_pc_i  input  1  EX redirects the PC (taken branch or jump).
REQ-012 mem_write_rd_i  input  1  MEM instruction writes rd.
REQ-013 mem_rd_addr_i  input  5  MEM destination index.
REQ-014 mem_oper_valid_i  input  1  MEM stage holds a load or store (mem_oper not MEM_NOP).
REQ-015 dmem_ack_i  input  1  data memory has completed the MEM-stage access this cycle.
REQ-016 wb_write_rd_i  input  1  WB instruction writes rd.
REQ-017 wb_rd_addr_i  input  5  WB destination index.
REQ-018 pc_stall_o  output  1  hold the PC.
REQ-019 ifid_stall_o / ifid_flush_o  output  1 each  hold / bubble the IF/ID register.
REQ-020 idex_stall_o / idex_flush_o  output  1 each  hold / bubble the ID/EX register.
REQ-021 exmem_stall_o / exmem_flush_o  output  1 each  hold / bubble the EX/MEM register (EX stage stall_i/flush_i).
REQ-022 fwd_rs1_sel_o / fwd_rs2_sel_o  output  2 each  EX operand source: 0 register file, 1 MEM result, 2 WB result.
REQ-023 bus_err_o  output  1  one-cycle pulse on memory timeout.

Function
REQ-024 FSM states RUN and MEM_WAIT; a timeout counter of width clog2(MEM_TIMEOUT+1) counts cycles in MEM_WAIT.
REQ-025 RUN: mem_oper_valid_i=1 and dmem_ack_i=0 -> all stalls asserted combinationally this cycle; next state MEM_WAIT with counter=1.
REQ-026 MEM_WAIT: pc/ifid/idex/exmem stalls asserted, all flushes deasserted, forwarding selects unchanged; counter increments each cycle.
REQ-027 MEM_WAIT exit: dmem_ack_i=1 -> stalls drop in that same cycle, next state RUN, counter cleared.
REQ-028 MEM_WAIT timeout: counter==MEM_TIMEOUT with no ack -> bus_err_o=1 for that cycle, exmem_flush_o=1 (MEM op dropped), next state RUN; ack in the same cycle wins, no error.
REQ-029 Load-use (RUN, no memory stall): ex_wb_use_mem_i=1, ex_write_rd_i=1, ex_rd_addr_i!=0 and equal to id_rs1 or id_rs2 -> pc_stall, ifid_stall, idex_flush asserted for exactly one cycle.
REQ-030 Redirect (RUN, no memory stall): ex_load_pc_i=1 -> ifid_flush and idex_flush asserted, no stalls; overrides a simultaneous load-use.
REQ-031 Priority: memory stall > redirect > load-use; stall and flush never both asserted on the same register.
REQ-032 Forwarding per operand: MEM match (mem_write_rd_i, rd!=0, rd==ex_rsN) -> 1; else WB match -> 2; else 0; x0 never forwarded.
REQ-033 Only the FSM, counter and registered bus_err source are sequential; stall/flush/forward outputs are combinational from inputs and state.

Reset
REQ-034 rstn_i low, at any time including mid-MEM_WAIT: state RUN, counter 0, bus_err_o 0, all stalls/flushes 0; pending access discarded without error.

Structure
REQ-035 Shared core package holds fwd_sel_t (FWD_NONE, FWD_MEM, FWD_WB) and ctrl_state_t (CTRL_RUN, CTRL_MEM_WAIT).
REQ-036 Forwarding logic in sub-module forward_unit, instantiated once per operand.

Verification
REQ-037 ex load rd=5, id_rs2=5 -> one cycle pc_stall=ifid_stall=idex_flush=1, then 0; same with rd=0 -> no stall.
REQ-038 ex_load_pc_i=1 together with that load-use hazard -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-039 mem_oper_valid_i=1, ack after 3 cycles -> all stalls high exactly 3 cycles, low in the ack cycle, state RUN.
REQ-040 MEM_TIMEOUT=4, no ack -> bus_err_o and exmem_flush_o pulse in 4th wait cycle, then RUN.
REQ-041 ex_rs1=7, mem rd=7, wb rd=7 both writing -> fwd_rs1_sel=1; mem_write_rd=0 -> 2; rd=0 -> 0.
REQ-042 rstn_i low during MEM_WAIT -> outputs 0 immediately, bus_err_o never asserted.
